rom_load_ctrl: RTL and testbench
================================

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: number of CLK cycles CORE_RESET stays asserted after the download ends.
REQ-002 Parameter TOTAL_BYTES, default 'hA0200: exact byte count of a complete ROM image.
REQ-003 CLK  in  1  the single clock for the loader stream and the ROM write ports.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 IOCTL_DOWNLOAD  in  1  high while an image is streaming.
REQ-006 IOCTL_WR  in  1  single-cycle byte strobe.
REQ-007 IOCTL_ADDR  in  25  byte address of IOCTL_DOUT.
REQ-008 IOCTL_DOUT  in  8  byte data.
REQ-009 ROM_ADDR  out  25  registered write address to the ROM banks.
REQ-010 ROM_DATA  out  8  registered write data.
REQ-011 ROM_WR  out  1  registered write strobe.
REQ-012 ROM_CS  out  9  one-hot bank select, bit 8..0 = ep1, ep2, ep3, mask1..mask4, prom1, prom2.
REQ-013 CORE_RESET  out  1  high = hold the game core in reset.
REQ-014 LOAD_DONE  out  1  high = complete, error-free image loaded and hold expired.
REQ-015 LOAD_ERR  out  1  sticky error flag for the current download.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, FLUSH, HOLD and DONE.
REQ-017 A rising edge of IOCTL_DOWNLOAD SHALL move the FSM to LOAD from any state, clearing the byte counter, expected address, LOAD_ERR and LOAD_DONE, and asserting CORE_RESET.
REQ-018 In LOAD, each IOCTL_WR SHALL produce exactly one ROM_WR pulse one cycle later, with ROM_ADDR, ROM_DATA and ROM_CS registered from the same sample.
REQ-019 IOCTL_WR in any state other than LOAD SHALL be ignored.
REQ-020 Bank decode thresholds:
  - ep1 < 'h10000
  - ep2 < 'h18000
  - ep3 < 'h20000
  - mask1 < 'h40000
  - mask2 < 'h60000
  - mask3 < 'h80000
  - mask4 < 'hA0000
  - prom1 < 'hA0100
  - prom2 < 'hA0200
REQ-021 An address >= TOTAL_BYTES SHALL produce no ROM_WR (ROM_CS = 0), SHALL NOT increment the byte counter, and SHALL set LOAD_ERR.
REQ-022 An in-range address not equal to the expected address (0 at start, then previous accepted address + 1) SHALL still be written and SHALL set LOAD_ERR.
REQ-023 The byte counter SHALL be 21 bits and SHALL saturate at all-ones.
REQ-024 A falling edge of IOCTL_DOWNLOAD in LOAD SHALL move the FSM to FLUSH for exactly one cycle, so any pending ROM_WR completes.
REQ-025 Leaving FLUSH, the FSM SHALL set LOAD_ERR if the byte count != TOTAL_BYTES, then enter HOLD with a down-counter loaded with HOLD_CYCLES-1.
REQ-026 HOLD SHALL move to DONE when its counter reaches 0; HOLD_CYCLES = 0 SHALL behave as 1.
REQ-027 In DONE: CORE_RESET = LOAD_ERR, and LOAD_DONE = ~LOAD_ERR.
REQ-028 IOCTL_WR coincident with the rising edge of IOCTL_DOWNLOAD SHALL be accepted as the first byte.
REQ-029 IOCTL_WR coincident with the falling edge SHALL be accepted and written during FLUSH.

Reset
REQ-030 While RESET_N = 0, the outputs SHALL be:
  - FSM = IDLE
  - ROM_WR = 0, ROM_CS = 0, ROM_ADDR = 0, ROM_DATA = 0
  - CORE_RESET = 1, LOAD_DONE = 0, LOAD_ERR = 0
  - all counters = 0
REQ-031 Reset asserted mid-LOAD SHALL abort the download with no further ROM_WR.
REQ-032 After reset is released, the block SHALL wait in IDLE for a new rising edge of IOCTL_DOWNLOAD; a download already high at release SHALL NOT start LOAD.

Structure
REQ-033 Package rom_load_pkg SHALL hold the FSM state enum, the bank index enum, the region limit constants and the TOTAL_BYTES default.
REQ-034 Bank decoding SHALL be a combinational sub-module rom_region_dec (25-bit address in; 9-bit one-hot select plus out_of_range out), instantiated once.

Verification
REQ-035 Full image, sequential bytes 0..'hA01FF, HOLD_CYCLES = 16 -> 'hA0200 ROM_WR pulses with the ROM_CS transitions at the region limits; LOAD_DONE = 1 and CORE_RESET = 0 exactly 18 cycles after the download falls.
REQ-036 Short image ending at 'h9FFFF -> LOAD_ERR = 1, LOAD_DONE = 0, CORE_RESET stays 1.
REQ-037 Byte written at 'hA0200 -> no ROM_WR for it; LOAD_ERR = 1; byte counter unchanged.
REQ-038 Address skip 'h0FFFF -> 'h10001 -> byte written with ROM_CS = ep2; LOAD_ERR = 1.
REQ-039 RESET_N pulsed low at byte 'h5000 -> ROM_WR stops at once; all outputs at reset values; next download completes cleanly.
REQ-040 Second download started in DONE -> LOAD_DONE clears and CORE_RESET = 1 on the cycle after the rising edge.

Source files
------------

// File: rtl/rom_load_pkg.sv
`timescale 1ns/1ps
// rom_load_pkg: shared types and constants for the ROM download controller.
//   load_state_e  : controller FSM states
//   bank_e        : bank index; the value is the bit position in the one-hot select
//   LIM_*         : exclusive upper byte address of each bank region
//   TOTAL_BYTES_DEF : byte count of a complete ROM image
package rom_load_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned CS_W   = 9;
    localparam int unsigned CNT_W  = 21;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } load_state_e;

    typedef enum logic [3:0] {
        BANK_PROM2 = 4'd0,
        BANK_PROM1 = 4'd1,
        BANK_MASK4 = 4'd2,
        BANK_MASK3 = 4'd3,
        BANK_MASK2 = 4'd4,
        BANK_MASK1 = 4'd5,
        BANK_EP3   = 4'd6,
        BANK_EP2   = 4'd7,
        BANK_EP1   = 4'd8
    } bank_e;

    localparam logic [ADDR_W-1:0] LIM_EP1   = 25'h0010000;
    localparam logic [ADDR_W-1:0] LIM_EP2   = 25'h0018000;
    localparam logic [ADDR_W-1:0] LIM_EP3   = 25'h0020000;
    localparam logic [ADDR_W-1:0] LIM_MASK1 = 25'h0040000;
    localparam logic [ADDR_W-1:0] LIM_MASK2 = 25'h0060000;
    localparam logic [ADDR_W-1:0] LIM_MASK3 = 25'h0080000;
    localparam logic [ADDR_W-1:0] LIM_MASK4 = 25'h00A0000;
    localparam logic [ADDR_W-1:0] LIM_PROM1 = 25'h00A0100;
    localparam logic [ADDR_W-1:0] LIM_PROM2 = 25'h00A0200;

    localparam logic [ADDR_W-1:0] TOTAL_BYTES_DEF = 25'h00A0200;

    // One-hot chip select for a bank index.
    function automatic logic [CS_W-1:0] bank_sel(input bank_e bank);
        return 9'd1 << bank;
    endfunction

endpackage

// File: rtl/rom_region_dec.sv
`timescale 1ns/1ps
// rom_region_dec: combinational bank decoder for a loader byte address.
//   addr         in  25  byte address from the download stream
//   sel          out 9   one-hot bank select (bit 8..0 = ep1..prom2), 0 when out of range
//   out_of_range out 1   address at or beyond the image size, or outside every bank
module rom_region_dec
    import rom_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TOTAL_BYTES = TOTAL_BYTES_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [CS_W-1:0]   sel,
    output logic              out_of_range
);

    logic [CS_W-1:0] bank_sel_s;

    // Priority compare against the ascending region limits
    always_comb begin
        bank_sel_s = 9'd0;
        if (addr < LIM_EP1) begin
            bank_sel_s = bank_sel(BANK_EP1);
        end else if (addr < LIM_EP2) begin
            bank_sel_s = bank_sel(BANK_EP2);
        end else if (addr < LIM_EP3) begin
            bank_sel_s = bank_sel(BANK_EP3);
        end else if (addr < LIM_MASK1) begin
            bank_sel_s = bank_sel(BANK_MASK1);
        end else if (addr < LIM_MASK2) begin
            bank_sel_s = bank_sel(BANK_MASK2);
        end else if (addr < LIM_MASK3) begin
            bank_sel_s = bank_sel(BANK_MASK3);
        end else if (addr < LIM_MASK4) begin
            bank_sel_s = bank_sel(BANK_MASK4);
        end else if (addr < LIM_PROM1) begin
            bank_sel_s = bank_sel(BANK_PROM1);
        end else if (addr < LIM_PROM2) begin
            bank_sel_s = bank_sel(BANK_PROM2);
        end else begin
            bank_sel_s = 9'd0;
        end
    end

    // A byte with no bank to land in is treated like one past the image end
    always_comb begin
        sel          = 9'd0;
        out_of_range = 1'b0;
        if ((addr >= TOTAL_BYTES) || (bank_sel_s == 9'd0)) begin
            sel          = 9'd0;
            out_of_range = 1'b1;
        end else begin
            sel          = bank_sel_s;
            out_of_range = 1'b0;
        end
    end

endmodule

// File: rtl/rom_load_ctrl.sv
`timescale 1ns/1ps
// rom_load_ctrl: turns the loader byte stream into registered ROM bank writes,
// checks the image for completeness/ordering, and sequences the core reset.
//   clk, reset_n              clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout  loader stream in
//   rom_addr/data/wr/cs       registered ROM write port out
//   core_reset                high holds the game core in reset
//   load_done                 clean image loaded and hold time expired
//   load_err                  sticky error flag of the current download
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int unsigned       HOLD_CYCLES = 16,
    parameter logic [ADDR_W-1:0] TOTAL_BYTES = TOTAL_BYTES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_wr,
    output logic [CS_W-1:0]   rom_cs,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err
);

    // HOLD_CYCLES of 0 behaves as 1, so the counter is always loaded with at least 0.
    localparam int unsigned       HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned       HOLD_LOAD_I = (HOLD_CYCLES > 1) ? (HOLD_CYCLES - 1) : 0;
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_LOAD_I[HOLD_W-1:0];

    load_state_e       state_r, state_nxt_s;
    logic              dl_prev_r;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [ADDR_W-1:0] exp_r, exp_nxt_s;
    logic              err_r, err_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_nxt_s;
    logic [ADDR_W-1:0] rom_addr_r, addr_nxt_s;
    logic [7:0]        rom_data_r, data_nxt_s;
    logic              rom_wr_r, wr_nxt_s;
    logic [CS_W-1:0]   rom_cs_r, cs_nxt_s;
    logic              core_reset_r, core_reset_nxt_s;
    logic              load_done_r, load_done_nxt_s;
    logic [CS_W-1:0]   region_sel_s;
    logic              out_of_range_s;
    logic              rise_s, fall_s, accept_s;

    rom_region_dec #(
        .TOTAL_BYTES (TOTAL_BYTES)
    ) u_region_dec (
        .addr         (ioctl_addr),
        .sel          (region_sel_s),
        .out_of_range (out_of_range_s)
    );

    // dl_prev_r resets high so a download already active at reset release is not an edge.
    assign rise_s   = ioctl_download & ~dl_prev_r;
    assign fall_s   = ~ioctl_download & dl_prev_r;
    // A strobe on the starting edge is the first byte; one on the ending edge is still in LOAD.
    assign accept_s = ioctl_wr & (rise_s | (state_r == ST_LOAD));

    // Next-state, image bookkeeping and ROM write-port values
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        exp_nxt_s   = exp_r;
        err_nxt_s   = err_r;
        hold_nxt_s  = hold_cnt_r;
        wr_nxt_s    = 1'b0;
        cs_nxt_s    = 9'd0;
        addr_nxt_s  = rom_addr_r;
        data_nxt_s  = rom_data_r;

        if (rise_s) begin
            state_nxt_s = ST_LOAD;
            cnt_nxt_s   = {CNT_W{1'b0}};
            exp_nxt_s   = {ADDR_W{1'b0}};
            err_nxt_s   = 1'b0;
            hold_nxt_s  = {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_LOAD: begin
                    if (fall_s) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if ({{(ADDR_W-CNT_W){1'b0}}, cnt_r} != TOTAL_BYTES) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                    hold_nxt_s  = HOLD_LOAD;
                    state_nxt_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        hold_nxt_s  = hold_cnt_r - HOLD_W'(1);
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DONE: state_nxt_s = ST_DONE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end

        // Uses the post-clear bookkeeping so a byte on the starting edge is checked against 0.
        if (accept_s) begin
            if (out_of_range_s) begin
                err_nxt_s = 1'b1;
            end else begin
                wr_nxt_s   = 1'b1;
                cs_nxt_s   = region_sel_s;
                addr_nxt_s = ioctl_addr;
                data_nxt_s = ioctl_dout;
                if (ioctl_addr != exp_nxt_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_nxt_s;
                end
                exp_nxt_s = ioctl_addr + 25'd1;
                if (cnt_nxt_s != {CNT_W{1'b1}}) begin
                    cnt_nxt_s = cnt_nxt_s + 21'd1;
                end else begin
                    cnt_nxt_s = cnt_nxt_s;
                end
            end
        end else begin
            wr_nxt_s = 1'b0;
        end
    end

    // Core reset / done status follow the state being entered, so they change with it
    always_comb begin
        core_reset_nxt_s = 1'b1;
        load_done_nxt_s  = 1'b0;
        if (state_nxt_s == ST_DONE) begin
            core_reset_nxt_s = err_nxt_s;
            load_done_nxt_s  = ~err_nxt_s;
        end else begin
            core_reset_nxt_s = 1'b1;
            load_done_nxt_s  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            dl_prev_r    <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
            exp_r        <= {ADDR_W{1'b0}};
            err_r        <= 1'b0;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            rom_addr_r   <= {ADDR_W{1'b0}};
            rom_data_r   <= 8'd0;
            rom_wr_r     <= 1'b0;
            rom_cs_r     <= 9'd0;
            core_reset_r <= 1'b1;
            load_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dl_prev_r    <= ioctl_download;
            cnt_r        <= cnt_nxt_s;
            exp_r        <= exp_nxt_s;
            err_r        <= err_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            rom_addr_r   <= addr_nxt_s;
            rom_data_r   <= data_nxt_s;
            rom_wr_r     <= wr_nxt_s;
            rom_cs_r     <= cs_nxt_s;
            core_reset_r <= core_reset_nxt_s;
            load_done_r  <= load_done_nxt_s;
        end
    end

    assign rom_addr   = rom_addr_r;
    assign rom_data   = rom_data_r;
    assign rom_wr     = rom_wr_r;
    assign rom_cs     = rom_cs_r;
    assign core_reset = core_reset_r;
    assign load_done  = load_done_r;
    assign load_err   = err_r;

endmodule

// File: tb/tb_rom_load_ctrl.sv
`timescale 1ns/1ps
// tb_rom_load_ctrl: two loaders share one stimulus stream. Instance 0 uses the
// full image size (bank decode, error paths); instance 1 uses a 'h300-byte
// image so a complete clean download fits in a short run.
module tb_rom_load_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [24:0] rom_addr_w   [2];
    logic [7:0]  rom_data_w   [2];
    logic        rom_wr_w     [2];
    logic [8:0]  rom_cs_w     [2];
    logic        core_reset_w [2];
    logic        load_done_w  [2];
    logic        load_err_w   [2];

    int n_total = 0;
    int n_pass  = 0;

    localparam int unsigned HOLD = 16;
    int unsigned img_size [2] = '{32'h000A0200, 32'h00000300};

    // reference model state
    int          cyc;
    bit          m_prev_dl;
    bit          m_loading [2];
    int unsigned m_cnt     [2];
    logic [24:0] m_exp     [2];
    bit          m_err     [2];
    int          m_flush   [2];
    int          m_done    [2];
    bit          m_wr      [2];
    logic [8:0]  m_cs      [2];
    logic [24:0] m_addr    [2];
    logic [7:0]  m_data    [2];

    always #5 clk = ~clk;

    rom_load_ctrl #(.HOLD_CYCLES(16)) dut_full (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_addr(rom_addr_w[0]), .rom_data(rom_data_w[0]), .rom_wr(rom_wr_w[0]),
        .rom_cs(rom_cs_w[0]), .core_reset(core_reset_w[0]), .load_done(load_done_w[0]),
        .load_err(load_err_w[0])
    );

    rom_load_ctrl #(.HOLD_CYCLES(16), .TOTAL_BYTES(25'h0000300)) dut_small (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_addr(rom_addr_w[1]), .rom_data(rom_data_w[1]), .rom_wr(rom_wr_w[1]),
        .rom_cs(rom_cs_w[1]), .core_reset(core_reset_w[1]), .load_done(load_done_w[1]),
        .load_err(load_err_w[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // bank from the region limit table
    function automatic logic [8:0] bank_of(input logic [24:0] a);
        logic [24:0] lim [9];
        lim = '{25'h10000, 25'h18000, 25'h20000, 25'h40000, 25'h60000,
                25'h80000, 25'hA0000, 25'hA0100, 25'hA0200};
        for (int j = 0; j < 9; j++) begin
            if (a < lim[j]) return 9'h100 >> j;
        end
        return 9'h000;
    endfunction

    task automatic model_reset();
        m_prev_dl = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_loading[i] = 1'b0; m_cnt[i] = 0; m_exp[i] = '0; m_err[i] = 1'b0;
            m_flush[i] = -1; m_done[i] = -1; m_wr[i] = 1'b0; m_cs[i] = '0;
            m_addr[i] = '0; m_data[i] = '0;
        end
    endtask

    // one clock edge of the behavioural loader
    task automatic model_edge();
        bit rise, fall, was_loading, accept;
        cyc++;
        rise = ioctl_download && !m_prev_dl;
        fall = !ioctl_download && m_prev_dl;
        for (int i = 0; i < 2; i++) begin
            was_loading = m_loading[i];
            m_wr[i] = 1'b0;
            m_cs[i] = '0;
            if (cyc == m_flush[i] && m_cnt[i] != img_size[i]) m_err[i] = 1'b1;
            if (rise) begin
                m_loading[i] = 1'b1; m_cnt[i] = 0; m_exp[i] = '0; m_err[i] = 1'b0;
                m_flush[i] = -1; m_done[i] = -1;
            end
            accept = ioctl_wr && (rise || was_loading);
            if (accept) begin
                if (ioctl_addr >= img_size[i]) begin
                    m_err[i] = 1'b1;
                end else begin
                    m_wr[i] = 1'b1; m_cs[i] = bank_of(ioctl_addr);
                    m_addr[i] = ioctl_addr; m_data[i] = ioctl_dout;
                    if (ioctl_addr != m_exp[i]) m_err[i] = 1'b1;
                    m_exp[i] = ioctl_addr + 25'd1;
                    if (m_cnt[i] < 32'h1FFFFF) m_cnt[i]++;
                end
            end
            if (fall && was_loading) begin
                m_loading[i] = 1'b0;
                m_flush[i] = cyc + 1;
                m_done[i] = cyc + 1 + ((HOLD == 0) ? 1 : HOLD);
            end
        end
        m_prev_dl = ioctl_download;
    endtask

    task automatic check_outputs();
        bit done_reached, e_core, e_done;
        for (int i = 0; i < 2; i++) begin
            done_reached = (m_done[i] >= 0) && (cyc >= m_done[i]);
            e_core = done_reached ? m_err[i] : 1'b1;
            e_done = done_reached && !m_err[i];
            check_val($sformatf("outs[%0d] wr/cs/core_reset/done/err", i),
                      {51'd0, rom_wr_w[i], rom_cs_w[i], core_reset_w[i], load_done_w[i], load_err_w[i]},
                      {51'd0, m_wr[i], m_cs[i], e_core, e_done, m_err[i]});
            check_val($sformatf("addr_data[%0d]", i),
                      {31'd0, rom_addr_w[i], rom_data_w[i]}, {31'd0, m_addr[i], m_data[i]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        else model_reset();
        #1;
        check_outputs();
    endtask

    task automatic put_byte(input logic [24:0] a);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = 8'($urandom);
        step();
        ioctl_wr = 1'b0;
    endtask

    // complete sequential image for the small instance, with random strobe gaps
    task automatic clean_image(input string tag);
        int lat;
        ioctl_download = 1'b1;
        put_byte(25'd0);                       // strobe on the rising edge
        for (int a = 1; a < 'h2FF; a++) begin
            if ($urandom_range(0, 3) == 0) step();
            put_byte(25'(a));
        end
        ioctl_download = 1'b0;
        put_byte(25'h2FF);                     // strobe on the falling edge
        lat = 1;
        while (!load_done_w[1] && lat < 40) begin
            step();
            lat++;
        end
        check_val({tag, " done latency"}, lat, 18);
        check_val({tag, " small err"}, load_err_w[1], 1'b0);
        check_val({tag, " small core_reset"}, core_reset_w[1], 1'b0);
        check_val({tag, " full short err"}, load_err_w[0], 1'b1);
        check_val({tag, " full core_reset"}, core_reset_w[0], 1'b1);
        check_val({tag, " full done"}, load_done_w[0], 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] lim [9];
        logic [24:0] nxt;
        cyc = 0;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0;
        model_reset();
        repeat (3) step();

        // download already high at reset release must not start a load
        ioctl_download = 1'b1;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ioctl_wr = 1'($urandom_range(0, 1)); ioctl_addr = 25'(k); ioctl_dout = 8'($urandom);
            step();
        end
        check_val("no start after reset: core_reset", core_reset_w[1], 1'b1);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        repeat (2) step();

        clean_image("image1");

        // restart from DONE
        ioctl_download = 1'b1;
        step();
        check_val("restart done clears", load_done_w[1], 1'b0);
        check_val("restart core_reset", core_reset_w[1], 1'b1);

        // region limits on the full instance
        lim = '{25'h10000, 25'h18000, 25'h20000, 25'h40000, 25'h60000,
                25'h80000, 25'hA0000, 25'hA0100, 25'hA0200};
        for (int j = 0; j < 9; j++) begin
            put_byte(lim[j] - 25'd1);
            put_byte(lim[j]);
        end
        check_val("oor write suppressed", rom_wr_w[0], 1'b0);
        put_byte(25'h0FFFF);
        put_byte(25'h10001);
        check_val("skip cs ep2", rom_cs_w[0], 9'h080);
        check_val("skip wr", rom_wr_w[0], 1'b1);
        check_val("skip err", load_err_w[0], 1'b1);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) step();
            put_byte(25'($urandom_range(0, 32'hA03FF)));
        end
        ioctl_download = 1'b0;
        repeat (22) step();

        // reset in the middle of a download
        ioctl_download = 1'b1;
        for (int a = 0; a <= 'h5000; a++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'($urandom);
            step();
        end
        check_val("pre-reset wr", rom_wr_w[0], 1'b1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_val("abort wr", rom_wr_w[0], 1'b0);
        repeat (3) step();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ioctl_addr = 25'(k);
            step();
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        repeat (2) step();
        clean_image("after reset");

        // random downloads
        for (int r = 0; r < 4; r++) begin
            ioctl_download = 1'b1;
            ioctl_wr = 1'b0;
            step();
            nxt = '0;
            for (int k = 0; k < int'($urandom_range(16, 48)); k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 3) != 0) begin
                        put_byte(nxt);
                    end else begin
                        put_byte(25'($urandom_range(0, 32'h320)));
                    end
                    nxt = ioctl_addr + 25'd1;
                end else begin
                    step();
                end
            end
            ioctl_download = 1'b0;
            repeat (20) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
